// File: rtl/dcache_pkg.sv
// Shared types and size helpers for the direct-mapped data cache.
//   state_t  : controller states
//   log2i    : ceil(log2(n)) for sizing address fields
//   tag_bits : tag width left over after offset/word/index fields
package dcache_pkg;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  function automatic int log2i(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  function automatic int tag_bits(input int addr_w, input int sets, input int line_words);
    return addr_w - log2i(sets) - log2i(line_words) - 2;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag / valid / data storage for dcache_direct.
//   idx, word        : line and word select (shared by read and write)
//   rd_tag/valid/data: combinational read of the selected line/word
//   wr_en, wr_be     : byte-enabled word write into data storage
//   val_set, wr_tag  : mark line valid and record its tag
//   val_clr          : invalidate selected line
//   rst_i            : synchronous clear of every valid bit (tags/data untouched)
module dcache_array #(
  parameter int SETS       = 32,
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = 5,
  parameter int WRD_W      = 2,
  parameter int TAG_W      = 23
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] idx,
  input  logic [WRD_W-1:0] word,
  output logic [TAG_W-1:0] rd_tag,
  output logic             rd_valid,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [3:0]       wr_be,
  input  logic [31:0]      wr_data,
  input  logic             val_set,
  input  logic             val_clr,
  input  logic [TAG_W-1:0] wr_tag
);

  logic [SETS-1:0]                   valid;
  logic [TAG_W-1:0]                  tag_ram  [SETS];
  logic [LINE_WORDS-1:0][31:0]       data_ram [SETS];

  assign rd_valid = valid[idx];
  assign rd_tag   = tag_ram[idx];
  assign rd_data  = data_ram[idx][word];

  // Reset wins over a same-cycle line fill so an interrupted refill stays invalid.
  always_ff @(posedge clk_i) begin
    if (rst_i)        valid <= '0;
    else if (val_set) valid[idx] <= 1'b1;
    else if (val_clr) valid[idx] <= 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (val_set) tag_ram[idx] <= wr_tag;
    if (wr_en)
      for (int b = 0; b < 4; b++)
        if (wr_be[b]) data_ram[idx][word][8*b +: 8] <= wr_data[8*b +: 8];
  end

endmodule

// File: rtl/dcache_direct.sv
// Direct-mapped, write-through, no-write-allocate data cache (MEM stage).
//   CPU side : req_i/we_i/addr_i/be_i/wdata_i in, rdata_o/stall_o out.
//              Load hits answer in the same cycle; misses and stores stall.
//   Mem side : single-word req/ready handshake (mem_req_o, mem_we_o,
//              mem_addr_o, mem_be_o, mem_wdata_o, mem_ready_i, mem_rdata_i).
//              A miss refills LINE_WORDS words in ascending order.
//   clk_i / rst_i: rising-edge clock, synchronous active-high reset.
module dcache_direct
  import dcache_pkg::*;
#(
  parameter int SETS       = 32,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [3:0]        be_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic [31:0]       mem_rdata_i
);

  localparam int WB    = log2i(LINE_WORDS);
  localparam int IB    = log2i(SETS);
  localparam int TAG_W = tag_bits(ADDR_W, SETS, LINE_WORDS);
  localparam int WRD_W = (WB > 0) ? WB : 1;
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS*4 - 1);
  localparam logic [ADDR_W-1:0] WORD_MASK = ADDR_W'(3);
  localparam logic [WRD_W-1:0]  LAST_WRD  = WRD_W'(LINE_WORDS - 1);

  state_t state, state_n;
  logic [WRD_W-1:0] cnt, word, arr_word;
  logic [IB-1:0]    idx;
  logic [TAG_W-1:0] tag, rd_tag;
  logic             rd_valid, hit, st_done;
  logic [31:0]      rd_data, wr_data;
  logic [3:0]       wr_be;
  logic             wr_en, val_set, val_clr, cnt_inc, cnt_clr;

  assign idx  = IB'(addr_i >> (WB + 2));
  assign tag  = TAG_W'(addr_i >> (IB + WB + 2));
  assign word = (WB > 0) ? WRD_W'(addr_i >> 2) : '0;
  assign hit  = rd_valid && (rd_tag == tag);

  dcache_array #(
    .SETS(SETS), .LINE_WORDS(LINE_WORDS), .IDX_W(IB), .WRD_W(WRD_W), .TAG_W(TAG_W)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .idx     (idx),
    .word    (arr_word),
    .rd_tag  (rd_tag),
    .rd_valid(rd_valid),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_be   (wr_be),
    .wr_data (wr_data),
    .val_set (val_set),
    .val_clr (val_clr),
    .wr_tag  (tag)
  );

  always_comb begin
    state_n     = state;
    stall_o     = 1'b0;
    rdata_o     = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = addr_i & ~WORD_MASK;
    mem_be_o    = 4'hf;
    mem_wdata_o = '0;
    arr_word    = word;
    wr_en       = 1'b0;
    wr_be       = be_i;
    wr_data     = wdata_i;
    val_set     = 1'b0;
    val_clr     = 1'b0;
    cnt_inc     = 1'b0;
    cnt_clr     = 1'b0;
    case (state)
      IDLE: if (req_i) begin
        if (we_i) begin
          // st_done: the held store was just written; release the pipeline
          // instead of issuing it a second time.
          if (!st_done) begin
            stall_o = 1'b1;
            state_n = WRITE;
          end
        end else if (hit) begin
          rdata_o = rd_data;
        end else begin
          stall_o = 1'b1;
          val_clr = 1'b1;
          cnt_clr = 1'b1;
          state_n = REFILL;
        end
      end
      REFILL: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = (addr_i & ~LINE_MASK) | (ADDR_W'(cnt) << 2);
        arr_word   = cnt;
        wr_be      = 4'hf;
        wr_data    = mem_rdata_i;
        if (mem_ready_i) begin
          wr_en   = 1'b1;
          cnt_inc = 1'b1;
          if (cnt == LAST_WRD) begin
            val_set = 1'b1;
            state_n = IDLE;
          end
        end
      end
      WRITE: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_be_o    = be_i;
        mem_wdata_o = wdata_i;
        if (mem_ready_i) begin
          wr_en   = hit;   // no allocate on a store miss
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      st_done <= 1'b0;
    end else begin
      state   <= state_n;
      st_done <= (state == WRITE) && mem_ready_i;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dcache_direct.sv
// Bench for dcache_direct: transaction-level reference model (memory image +
// which line each set holds), random memory latency, directed scenarios then
// random loads/stores over a few conflicting tags.
module tb_dcache_direct;
  localparam int SETS = 32, LW = 4, AW = 32;
  localparam int LB = LW * 4;   // bytes per line

  logic        clk = 0, rst = 1, req = 0, we = 0;
  logic [31:0] addr = 0, wdata = 0, mem_rdata = 0;
  logic [3:0]  be = 0;
  logic        mem_ready = 0;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic        stall, mem_req, mem_we;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  dcache_direct #(.SETS(SETS), .LINE_WORDS(LW), .ADDR_W(AW)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .be_i(be),
    .wdata_i(wdata), .rdata_o(rdata), .stall_o(stall), .mem_req_o(mem_req),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Main memory image; untouched words read back their own address.
  logic [31:0] mem [int unsigned];
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (mem.exists(wa)) return mem[wa];
    return wa;
  endfunction

  // Cache model: which line number each set holds. Write-through keeps the
  // cached copy equal to the memory image, so data comes from mem_rd().
  bit          rv    [SETS];
  logic [31:0] rline [SETS];
  int  txn_id = 0, seen_id = 0, nw = 0;
  bit  sdone = 0;
  int  obs_stalls = 0, obs_words = 0, obs_reqcyc = 0;
  bit  obs_done = 0;
  logic [31:0] obs_rdata = 0;
  bit  prev_pend = 0;
  logic [31:0] p_addr, p_wdata;
  logic [3:0]  p_be;
  logic        p_we;

  // Memory responder: `lat` wait cycles per word, noise on ready while idle.
  int lat = 0, wc = 0;
  always begin
    @(posedge clk); #2;
    if (mem_req) begin
      if (wc >= lat) begin mem_ready = 1; mem_rdata = mem_rd(mem_addr); wc = 0; end
      else begin mem_ready = 0; mem_rdata = $urandom; wc++; end
    end else begin
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      wc = 0;
    end
  end

  always @(negedge clk) begin : cmp
    logic [31:0] ln, w;
    int st;
    bit hit;
    ln = addr / LB;
    st = int'(ln % SETS);
    if (rst) begin
      for (int i = 0; i < SETS; i++) rv[i] = 0;
      nw = 0; sdone = 0; prev_pend = 0;
    end else begin
      if (txn_id != seen_id) begin
        seen_id = txn_id; nw = 0; sdone = 0;
        obs_stalls = 0; obs_words = 0; obs_reqcyc = 0; obs_done = 0;
      end
      if (prev_pend) begin
        chk("hold_req",   {31'b0, mem_req}, 32'd1);
        chk("hold_addr",  mem_addr, p_addr);
        chk("hold_we",    {31'b0, mem_we}, {31'b0, p_we});
        chk("hold_be",    {28'b0, mem_be}, {28'b0, p_be});
        chk("hold_wdata", mem_wdata, p_wdata);
      end
      if (!req) begin
        chk("idle_stall", {31'b0, stall}, 32'd0);
        chk("idle_req",   {31'b0, mem_req}, 32'd0);
      end else if (we) begin
        chk("st_stall", {31'b0, stall}, {31'b0, !sdone});
        if (mem_req) begin
          chk("st_we",    {31'b0, mem_we}, 32'd1);
          chk("st_addr",  mem_addr, {addr[31:2], 2'b00});
          chk("st_be",    {28'b0, mem_be}, {28'b0, be});
          chk("st_wdata", mem_wdata, wdata);
        end
        if (sdone) begin
          chk("st_done_req", {31'b0, mem_req}, 32'd0);
          obs_done = 1;
        end
      end else begin
        hit = rv[st] && rline[st] == ln;
        chk("ld_stall", {31'b0, stall}, {31'b0, !hit});
        if (hit) begin
          chk("ld_rdata", rdata, mem_rd(addr));
          chk("ld_hit_req", {31'b0, mem_req}, 32'd0);
          obs_done = 1; obs_rdata = rdata;
        end else begin
          rv[st] = 0;
          if (mem_req) begin
            chk("rf_we",   {31'b0, mem_we}, 32'd0);
            chk("rf_addr", mem_addr, 32'(ln * LB + nw * 4));
          end
        end
      end
      if (!mem_req && !mem_we) chk("idle_be", {28'b0, mem_be}, 32'hf);
      if (stall)   obs_stalls++;
      if (mem_req) obs_reqcyc++;
      if (mem_req && mem_ready) begin
        if (mem_we) begin
          w = mem_rd(mem_addr);
          for (int b = 0; b < 4; b++) if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
          mem[{mem_addr[31:2], 2'b00}] = w;
          sdone = 1;
        end else begin
          nw++; obs_words++;
          if (nw == LW) begin rv[st] = 1; rline[st] = ln; end
        end
      end
      prev_pend = mem_req && !mem_ready;
      p_addr = mem_addr; p_wdata = mem_wdata; p_be = mem_be; p_we = mem_we;
    end
  end

  // Present one request (called at posedge+1) and hold it until completion.
  task automatic op(input bit w_, input logic [31:0] a, input logic [3:0] b,
                    input logic [31:0] d, input int l);
    bit ok;
    ok = 0;
    lat = l; req = 1; we = w_; addr = a; be = b; wdata = d; txn_id++;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (obs_done) begin ok = 1; break; end
    end
    chk("op_done", {31'b0, ok}, 32'd1);
  endtask

  initial begin
    logic [31:0] ra;
    bit ok6;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_req",   {31'b0, mem_req}, 32'd0);
    chk("rst_we",    {31'b0, mem_we}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(posedge clk); #1;

    // 1: cold miss, 4 words, miss penalty LW+1
    op(0, 32'h100, 4'hf, 0, 0);
    chk("t1_stalls", obs_stalls, 5);
    chk("t1_words",  obs_words, 4);
    chk("t1_rdata",  obs_rdata, 32'h100);
    // 2: same-line hit
    op(0, 32'h108, 4'hf, 0, 0);
    chk("t2_stalls", obs_stalls, 0);
    chk("t2_reqcyc", obs_reqcyc, 0);
    chk("t2_rdata",  obs_rdata, 32'h108);
    // 3: store hit, 3 wait cycles; word 0x00000104 gets low half 0xBEEF
    op(1, 32'h104, 4'b0011, 32'hDEADBEEF, 3);
    chk("t3_reqcyc", obs_reqcyc, 4);
    chk("t3_stalls", obs_stalls, 5);
    op(0, 32'h104, 4'hf, 0, 0);
    chk("t3_stalls_ld", obs_stalls, 0);
    chk("t3_rdata", obs_rdata, 32'h0000BEEF);
    // 4: store miss does not allocate
    op(1, 32'h2000, 4'hf, 32'hCAFEF00D, 1);
    chk("t4_st_words", obs_words, 0);
    chk("t4_mem", mem_rd(32'h2000), 32'hCAFEF00D);
    op(0, 32'h2000, 4'hf, 0, 0);
    chk("t4_words", obs_words, 4);
    chk("t4_rdata", obs_rdata, 32'hCAFEF00D);
    // 5: conflict eviction in set 0x10
    op(0, 32'h100, 4'hf, 0, 0);
    chk("t5_hit", obs_words, 0);
    op(0, 32'h300, 4'hf, 0, 0);
    chk("t5_words", obs_words, 4);
    chk("t5_rdata", obs_rdata, 32'h300);
    op(0, 32'h100, 4'hf, 0, 0);
    chk("t5_reload", obs_words, 4);
    chk("t5_rdata2", obs_rdata, 32'h100);
    // 6: reset after the second refill word
    lat = 0; req = 1; we = 0; addr = 32'h500; txn_id++;
    ok6 = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (obs_words >= 2) begin ok6 = 1; break; end
    end
    chk("t6_two_words", {31'b0, ok6}, 32'd1);
    rst = 1; req = 0;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("t6_stall", {31'b0, stall}, 32'd0);
    chk("t6_req",   {31'b0, mem_req}, 32'd0);
    @(posedge clk); #1;
    op(0, 32'h500, 4'hf, 0, 0);
    chk("t6_words",  obs_words, 4);
    chk("t6_stalls", obs_stalls, 5);
    chk("t6_rdata",  obs_rdata, 32'h500);

    // random loads/stores over 4 tags sharing the same sets
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 4) == 0) begin req = 0; @(posedge clk); #1; end
      ra = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 127)) << 2);
      op($urandom_range(0, 2) == 0, ra, 4'($urandom_range(0, 15)), $urandom,
         $urandom_range(0, 3));
    end
    req = 0;
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
